// File: rtl/pe_packet_sender_pkg.sv
// Shared types and constants for the PE packet sender: operation stage/mode enums,
// the broadcast packet format and the per-mode packet index limits.
package pe_packet_sender_pkg;

    localparam int IFDATA_SIZE = 8;
    localparam int PKT_IDX_W   = 7;

    localparam logic [2:0]           FILTER_ROW_MAX    = 3'd4;
    localparam logic [PKT_IDX_W-1:0] MODE1_PKT_IDX_MAX = 7'd15;
    localparam logic [PKT_IDX_W-1:0] MODE2_PKT_IDX_MAX = 7'd31;
    localparam logic [PKT_IDX_W-1:0] MODE3_PKT_IDX_MAX = 7'd63;
    localparam logic [PKT_IDX_W-1:0] MODE4_PKT_IDX_MAX = 7'd95;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } OP_MODE;

    typedef enum logic {
        LOAD_FILTER = 1'b0,
        CONV        = 1'b1
    } OP_STAGE;

    typedef struct packed {
        logic                     valid;
        logic [PKT_IDX_W-1:0]     packet_idx;
        logic [4*IFDATA_SIZE-1:0] data;
    } PE_IN_PACKET;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } sender_state_t;

    function automatic logic [PKT_IDX_W-1:0] conv_idx_max(input OP_MODE mode);
        logic [PKT_IDX_W-1:0] max_idx;
        case (mode)
            MODE1:   max_idx = MODE1_PKT_IDX_MAX;
            MODE2:   max_idx = MODE2_PKT_IDX_MAX;
            MODE3:   max_idx = MODE3_PKT_IDX_MAX;
            default: max_idx = MODE4_PKT_IDX_MAX;
        endcase
        return max_idx;
    endfunction

    // MODE4 filters are only three rows tall.
    function automatic logic [2:0] filter_row_max(input OP_MODE mode);
        return (mode == MODE4) ? 3'd2 : FILTER_ROW_MAX;
    endfunction

endpackage

// File: rtl/pe_packet_sender_if.sv
// Control, buffer-read and PE broadcast signals of the packet sender.
// master = the sender itself, slave = the surrounding controller/buffer/PE array.
interface pe_packet_sender_if #(
    parameter int ADDR_W = 10,
    parameter int NUM_PE = 24
) ();
    import pe_packet_sender_pkg::*;

    logic                     start;
    OP_STAGE                  op_stage;
    OP_MODE                   mode;
    logic [ADDR_W-1:0]        base_addr;
    logic [9:0]               num_pkts;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [4*IFDATA_SIZE-1:0] rd_data;
    PE_IN_PACKET              pe_packet;
    logic [NUM_PE-1:0]        pe_full;
    logic [NUM_PE-1:0]        pe_error;
    logic                     busy;
    logic                     done;
    logic                     error;

    modport master (
        input  start, op_stage, mode, base_addr, num_pkts, rd_data, pe_full, pe_error,
        output rd_en, rd_addr, pe_packet, busy, done, error
    );

    modport slave (
        output start, op_stage, mode, base_addr, num_pkts, rd_data, pe_full, pe_error,
        input  rd_en, rd_addr, pe_packet, busy, done, error
    );

endinterface

// File: rtl/pkt_skid_fifo.sv
// Two-entry FIFO absorbing buffer read data while the PE array is stalled.
// Simultaneous push and pop are supported; pops on an empty FIFO are ignored.
module pkt_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       pop_eff;

    assign pop_eff = pop && (count_reg != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (push && !pop_eff) begin
            count_next = count_reg + 2'd1;
        end else if (!push && pop_eff) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_eff) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count     = count_reg;

endmodule

// File: rtl/pe_packet_sender.sv
// Reads packet data from the global buffer and broadcasts indexed packets to the PE array.
// Optional SENDER_STALL_CNT_EN adds a saturating stall_cnt output (stalled cycles with data pending).
module pe_packet_sender
    import pe_packet_sender_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NUM_PE = 24
) (
    input  logic               clk,
    input  logic               rst,
    pe_packet_sender_if.master bus
`ifdef SENDER_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);
    sender_state_t state_reg, state_next;

    logic [9:0]               num_pkts_reg;
    logic [9:0]               issued_cnt_reg;
    logic [9:0]               sent_cnt_reg;
    logic [ADDR_W-1:0]        base_addr_reg;
    OP_STAGE                  op_stage_reg;
    OP_MODE                   mode_reg;
    logic [2:0]               row_reg;
    logic [1:0]               filt_reg;
    logic [PKT_IDX_W-1:0]     conv_idx_reg;
    logic                     inflight_reg;
    logic                     error_reg;

    logic [NUM_PE-1:0]        full_vec;
    logic [NUM_PE-1:0]        err_vec;
    logic                     any_full;
    logic                     start_acc;
    logic                     send;
    logic                     rd_issue;
    logic                     last_read;
    logic                     last_send;
    logic [2:0]               occupancy;
    logic [1:0]               fifo_count;
    logic [4*IFDATA_SIZE-1:0] fifo_head;
    logic [PKT_IDX_W-1:0]     cur_idx;

    assign full_vec  = bus.pe_full;
    assign err_vec   = bus.pe_error;
    assign any_full  = |full_vec;
    assign start_acc = bus.start && (state_reg == IDLE);
    assign send      = (fifo_count != 2'd0) && !any_full;

    // Entries the FIFO will hold after this cycle; a read is only issued if its
    // data is guaranteed a free slot when it returns next cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, send};
    assign rd_issue  = (state_reg == FETCH) && (issued_cnt_reg != num_pkts_reg)
                       && (occupancy < 3'd2);
    assign last_read = rd_issue && (issued_cnt_reg == num_pkts_reg - 10'd1);
    assign last_send = send && (sent_cnt_reg == num_pkts_reg - 10'd1);

    pkt_skid_fifo #(
        .W(4*IFDATA_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (bus.rd_data),
        .pop       (send),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_pkts == 10'd0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (last_read) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_send) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_en     = rd_issue;
        bus.rd_addr   = '0;
        if (rd_issue) begin
            bus.rd_addr = base_addr_reg + ADDR_W'(issued_cnt_reg);
        end
        bus.busy      = (state_reg == FETCH) || (state_reg == SEND);
        bus.done      = (state_reg == FINISH);
        bus.error     = error_reg;
        bus.pe_packet = '0;
        if (send) begin
            bus.pe_packet.valid      = 1'b1;
            bus.pe_packet.packet_idx = cur_idx;
            bus.pe_packet.data       = fifo_head;
        end
    end

    always_comb begin
        cur_idx = conv_idx_reg;
        if (op_stage_reg == LOAD_FILTER) begin
            cur_idx = {{(PKT_IDX_W-5){1'b0}}, filt_reg, row_reg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_pkts_reg   <= '0;
            issued_cnt_reg <= '0;
            sent_cnt_reg   <= '0;
            base_addr_reg  <= '0;
            op_stage_reg   <= LOAD_FILTER;
            mode_reg       <= MODE1;
            row_reg        <= '0;
            filt_reg       <= '0;
            conv_idx_reg   <= '0;
            inflight_reg   <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (start_acc) begin
                num_pkts_reg   <= bus.num_pkts;
                base_addr_reg  <= bus.base_addr;
                op_stage_reg   <= bus.op_stage;
                mode_reg       <= bus.mode;
                issued_cnt_reg <= '0;
                sent_cnt_reg   <= '0;
                row_reg        <= '0;
                filt_reg       <= '0;
                conv_idx_reg   <= '0;
            end else begin
                if (rd_issue) begin
                    issued_cnt_reg <= issued_cnt_reg + 10'd1;
                end
                if (send) begin
                    sent_cnt_reg <= sent_cnt_reg + 10'd1;
                    if (op_stage_reg == LOAD_FILTER) begin
                        if (row_reg == filter_row_max(mode_reg)) begin
                            row_reg  <= '0;
                            filt_reg <= filt_reg + 2'd1;
                        end else begin
                            row_reg <= row_reg + 3'd1;
                        end
                    end else begin
                        conv_idx_reg <= (conv_idx_reg == conv_idx_max(mode_reg))
                                        ? '0 : conv_idx_reg + 1'b1;
                    end
                end
            end
        end
    end

    // A PE error arriving together with a start is kept rather than lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else if (|err_vec) begin
            error_reg <= 1'b1;
        end else if (start_acc) begin
            error_reg <= 1'b0;
        end
    end

`ifdef SENDER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (start_acc) begin
            stall_cnt_reg <= '0;
        end else if ((fifo_count != 2'd0) && any_full && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_packet_sender.sv
// Scoreboard bench for pe_packet_sender: expected packets are computed from the index
// rules and a buffer image, queued at start, and consumed by an independent monitor.
module tb_pe_packet_sender;
    import pe_packet_sender_pkg::*;

    localparam int ADDR_W = 10;
    localparam int NUM_PE = 24;
    localparam int BUDGET = 2000;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   accept_cyc, first_cyc, last_cyc, n_valid;
    int   txn_no = 0;
    bit   no_rd = 1'b0;
    exp_t exp_q[$];
    int   obs_idx[$];
    logic [31:0] mem [1024];

    pe_packet_sender_if #(.ADDR_W(ADDR_W), .NUM_PE(NUM_PE)) bus ();

`ifdef SENDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pe_packet_sender #(
        .ADDR_W(ADDR_W),
        .NUM_PE(NUM_PE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SENDER_STALL_CNT_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous buffer: data one cycle after the read strobe.
    initial forever begin
        @(posedge clk);
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_idx(input OP_STAGE st, input OP_MODE md, input int k);
        int period;
        period = 1;
        if (st == LOAD_FILTER) begin
            period = (md == MODE4) ? 3 : int'(FILTER_ROW_MAX) + 1;
            return ((k / period) % 4) * 8 + (k % period);
        end
        case (md)
            MODE1:   period = int'(MODE1_PKT_IDX_MAX) + 1;
            MODE2:   period = int'(MODE2_PKT_IDX_MAX) + 1;
            MODE3:   period = int'(MODE3_PKT_IDX_MAX) + 1;
            default: period = int'(MODE4_PKT_IDX_MAX) + 1;
        endcase
        return k % period;
    endfunction

    // Monitor: every valid packet must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.pe_packet.valid) begin
                    chk("valid_while_full", longint'(|bus.pe_full), 0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pkt: got idx %0d, required no packet (cycle %0d)",
                                 bus.pe_packet.packet_idx, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pkt_idx", longint'(bus.pe_packet.packet_idx), longint'(e.idx));
                        chk("pkt_data", longint'(bus.pe_packet.data), longint'(e.data));
                    end
                    obs_idx.push_back(int'(bus.pe_packet.packet_idx));
                    if (n_valid == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n_valid++;
                end else begin
                    chk("idle_pkt_zero",
                        longint'({bus.pe_packet.packet_idx, bus.pe_packet.data}), 0);
                end
                if (no_rd) chk("rd_en_without_pkts", longint'(bus.rd_en), 0);
            end
        end
    end

    task automatic do_start(input OP_STAGE st, input OP_MODE md,
                            input logic [9:0] base, input logic [9:0] n);
        for (int k = 0; k < int'(n); k++) begin
            exp_q.push_back('{model_idx(st, md, k), mem[(int'(base) + k) % 1024]});
        end
        obs_idx.delete();
        n_valid = 0;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.op_stage  = st;
        bus.mode      = md;
        bus.base_addr = base;
        bus.num_pkts  = n;
        @(posedge clk);
        #1;
        accept_cyc    = cyc;
        bus.start     = 1'b0;
        bus.base_addr = 10'($urandom);
        bus.num_pkts  = 10'($urandom);
        bus.mode      = OP_MODE'($urandom_range(0, 3));
    endtask

    // full_mode: 0 = never full, 1 = random single-PE full, 2 = pe_full[3] in cycles 2..6
    task automatic run_txn(input OP_STAGE st, input OP_MODE md, input logic [9:0] base,
                           input logic [9:0] n, input int full_mode);
        int rel;
        int done_cyc;
        bit got;
        txn_no++;
        $display("[TB] txn %0d stage=%s mode=%s base=%0d n=%0d full_mode=%0d",
                 txn_no, st.name(), md.name(), base, n, full_mode);
        no_rd = (n == 10'd0);
        do_start(st, md, base, n);
        @(negedge clk);
        chk("error_cleared_by_start", longint'(bus.error), 0);
        chk("busy_after_start", longint'(bus.busy), longint'(n != 10'd0));
        got = 1'b0;
        done_cyc = 0;
        for (int c = 0; c < BUDGET; c++) begin
            if (bus.done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            rel = cyc - accept_cyc;
            bus.pe_full = '0;
            if (full_mode == 1 && $urandom_range(0, 2) == 0)
                bus.pe_full[$urandom_range(0, NUM_PE - 1)] = 1'b1;
            if (full_mode == 2 && rel >= 2 && rel <= 6)
                bus.pe_full[3] = 1'b1;
            @(negedge clk);
        end
        bus.pe_full = '0;
        chk("done_seen", longint'(got), 1);
        if (got) begin
            if (n == 10'd0)
                chk("done_within_2", longint'((done_cyc - accept_cyc) <= 2), 1);
            else
                chk("done_after_last_pkt", longint'(done_cyc), longint'(last_cyc + 1));
            chk("pkts_outstanding", longint'(exp_q.size()), 0);
            chk("pkt_count", longint'(n_valid), longint'(n));
            if (full_mode == 0 && n != 10'd0)
                chk("pkts_consecutive", longint'(last_cyc - first_cyc), longint'(int'(n) - 1));
        end
        @(negedge clk);
        chk("done_one_cycle", longint'({bus.done, bus.busy}), 0);
        no_rd = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int ref_filt[7] = '{0, 1, 2, 8, 9, 10, 16};
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        bus.start     = 1'b0;
        bus.op_stage  = LOAD_FILTER;
        bus.mode      = MODE1;
        bus.base_addr = '0;
        bus.num_pkts  = '0;
        bus.rd_data   = '0;
        bus.pe_full   = '0;
        bus.pe_error  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", longint'(bus.rd_en), 0);
        chk("reset_pe_packet", longint'(bus.pe_packet), 0);
        chk("reset_busy_done_error", longint'({bus.busy, bus.done, bus.error}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_txn(CONV, MODE1, 10'd100, 10'd5, 0);
        run_txn(LOAD_FILTER, MODE4, 10'd200, 10'd7, 0);
        chk("filt_seq_len", longint'(obs_idx.size()), 7);
        for (int i = 0; i < 7 && i < obs_idx.size(); i++)
            chk("filt_seq_idx", longint'(obs_idx[i]), longint'(ref_filt[i]));

        run_txn(CONV, MODE2, 10'd1020, 10'd20, 2);
`ifdef SENDER_STALL_CNT_EN
        chk("stall_cnt", longint'(stall_cnt), 5);
`endif
        run_txn(CONV, MODE1, 10'd5, 10'd0, 0);

        // Sticky error: a single-cycle pulse while idle, cleared only by the next start.
        @(posedge clk);
        #1 bus.pe_error[7] = 1'b1;
        @(posedge clk);
        #1 bus.pe_error = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("error_sticky", longint'(bus.error), 1);
        run_txn(CONV, MODE1, 10'd300, 10'd40, 1);
        run_txn(LOAD_FILTER, MODE1, 10'd400, 10'd45, 0);

        for (int t = 0; t < 20; t++)
            run_txn(OP_STAGE'($urandom_range(0, 1)), OP_MODE'($urandom_range(0, 3)),
                    10'($urandom_range(0, 1023)), 10'($urandom_range(1, 40)),
                    int'($urandom_range(0, 1)));

        // Reset in the middle of a long transfer.
        txn_no++;
        $display("[TB] txn %0d reset during SEND", txn_no);
        do_start(CONV, MODE3, 10'd500, 10'd60);
        repeat (8) @(posedge clk);
        #1 bus.pe_error = 24'h000080;
        @(posedge clk);
        #1 bus.pe_error = '0;
        @(negedge clk);
        chk("error_set_midrun", longint'(bus.error), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rd_en", longint'(bus.rd_en), 0);
        chk("rst_pe_packet", longint'(bus.pe_packet), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_error", longint'(bus.error), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        run_txn(CONV, MODE1, 10'd600, 10'd12, 0);
        chk("restart_first_idx", longint'(obs_idx.size() > 0 ? obs_idx[0] : -1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
